stream_mux_2to1: RTL and testbench

Two-input, one-output stream merger with valid/ready handshakes, round-robin arbitration and packet locking. It is the merge-side counterpart of the 1-to-2 demultiplexer. Each output beat carries a source tag `out_sel`, so a downstream `demux_1to2`-style splitter can route beats back by `sel`. It sits between two producer streams and a single registered output channel.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/rr_arb2.sv | 22 ++
 rtl/stream_mux_2to1.sv | 89 ++++++++
 tb/tb_stream_mux_2to1.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the 2-to-1 stream merger.
package stream_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } mux_state_t;

  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin arbiter with an optional packet lock.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       lock_en,
  input  logic       lock_id,
  output logic [1:0] grant
);

  // A lock grants its owner regardless of the other side; ties go to the side not in ptr.
  always_comb begin
    grant = 2'b00;
    if (lock_en) begin
      grant = lock_id ? 2'b10 : 2'b01;
    end else if (req == 2'b11) begin
      grant = ptr ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/stream_mux_2to1.sv
// Two-input valid/ready stream merger with round-robin arbitration, packet
// locking and a single registered output stage tagged with the source.
module stream_mux_2to1
  import stream_mux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  mux_state_t state;
  logic       rr_ptr;
  logic [1:0] grant;
  logic       load_en_c;
  logic       acc0_c;
  logic       acc1_c;

  rr_arb2 u_arb (
    .req     ({in1_valid, in0_valid}),
    .ptr     (rr_ptr),
    .lock_en (state != IDLE),
    .lock_id (state == LOCK1),
    .grant   (grant)
  );

  assign load_en_c = !out_valid | out_ready;
  assign in0_ready = load_en_c & grant[0] & !rst;
  assign in1_ready = load_en_c & grant[1] & !rst;
  assign acc0_c    = in0_valid & in0_ready;
  assign acc1_c    = in1_valid & in1_ready;

  // Output register, lock FSM and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= SRC_IN0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      state     <= IDLE;
      rr_ptr    <= SRC_IN1;
    end else begin
      if (load_en_c) begin
        if (acc0_c) begin
          out_data  <= in0_data;
          out_last  <= in0_last;
          out_sel   <= SRC_IN0;
          out_valid <= 1'b1;
        end else if (acc1_c) begin
          out_data  <= in1_data;
          out_last  <= in1_last;
          out_sel   <= SRC_IN1;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (acc0_c) begin
            rr_ptr <= SRC_IN0;
            if (!in0_last) state <= LOCK0;
          end else if (acc1_c) begin
            rr_ptr <= SRC_IN1;
            if (!in1_last) state <= LOCK1;
          end
        end
        LOCK0:   if (acc0_c && in0_last) state <= IDLE;
        LOCK1:   if (acc1_c && in1_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_mux_2to1.sv
// Directed self-checking bench for stream_mux_2to1.
module tb_stream_mux_2to1;

  logic       clk;
  logic       rst;
  logic [7:0] in0_data;
  logic       in0_valid;
  logic       in0_last;
  logic       in0_ready;
  logic [7:0] in1_data;
  logic       in1_valid;
  logic       in1_last;
  logic       in1_ready;
  logic [7:0] out_data;
  logic       out_sel;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  int n_cmp = 0;
  int n_err = 0;

  stream_mux_2to1 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1);
    in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic s,
                         input logic l, input logic v);
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_sel"},   8'(out_sel), 8'(s));
    chk({tag, "_last"},  8'(out_last), 8'(l));
    chk({tag, "_valid"}, 8'(out_valid), 8'(v));
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_rdy0"}, 8'(in0_ready), 8'(r0));
    chk({tag, "_rdy1"}, 8'(in1_ready), 8'(r1));
  endtask

  initial begin
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [7:0] exp_data;
    logic       exp_sel;

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset state, and readies held low while rst is high.
    repeat (2) @(negedge clk);
    drive(1'b1, 8'h11, 1'b1, 1'b1, 8'h33, 1'b1);
    #1;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk_rdy("reset", 1'b0, 1'b0);

    // Single beat on in0.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    chk_rdy("single0_offer", 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1);
    #1;
    chk_out("single0", 8'h11, 1'b0, 1'b1, 1'b1);
    chk_rdy("single1_offer", 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk_out("single1", 8'h33, 1'b1, 1'b1, 1'b1);

    // Tie fairness: last winner was in1, so in0 wins first and grants alternate.
    cnt0 = 8'd0;
    cnt1 = 8'd0;
    exp_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 8'hA0 + cnt0, 1'b1, 1'b1, 8'hB0 + cnt1, 1'b1);
      #1;
      exp_sel = 1'(i % 2);
      chk_rdy("tie_grant", !exp_sel, exp_sel);
      if (i > 0) chk_out("tie_out", exp_data, !exp_sel, 1'b1, 1'b1);
      if (exp_sel == 1'b0) begin
        exp_data = 8'hA0 + cnt0;
        cnt0 = cnt0 + 8'd1;
      end else begin
        exp_data = 8'hB0 + cnt1;
        cnt1 = cnt1 + 8'd1;
      end
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk_out("tie_final", 8'hB1, 1'b1, 1'b1, 1'b1);

    // Packet lock: 3-beat in0 packet while in1 holds 0x55.
    @(negedge clk);
    drive(1'b1, 8'h01, 1'b0, 1'b1, 8'h55, 1'b1);
    #1;
    chk_rdy("lock_b0", 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h02, 1'b0, 1'b1, 8'h55, 1'b1);
    #1;
    chk_rdy("lock_b1", 1'b1, 1'b0);
    chk_out("lock_o1", 8'h01, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h03, 1'b1, 1'b1, 8'h55, 1'b1);
    #1;
    chk_rdy("lock_b2", 1'b1, 1'b0);
    chk_out("lock_o2", 8'h02, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1);
    #1;
    chk_rdy("lock_rel", 1'b0, 1'b1);
    chk_out("lock_o3", 8'h03, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk_out("lock_o4", 8'h55, 1'b1, 1'b1, 1'b1);

    // Backpressure: 0x22 buffered and held for 4 cycles.
    @(negedge clk);
    drive(1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 8'h23, 1'b1, 1'b1, 8'h66, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out("stall_hold", 8'h22, 1'b0, 1'b1, 1'b1);
      chk_rdy("stall_rdy", 1'b0, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drive(1'b1, 8'h23, 1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    chk_rdy("stall_release", 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk_out("stall_next", 8'h23, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("drain_valid", 8'(out_valid), 8'h00);

    // Reset in the middle of a 3-beat in1 packet.
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h91, 1'b0);
    #1;
    chk_rdy("mid_b0", 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h92, 1'b0);
    @(negedge clk);
    #1;
    chk_out("mid_o2", 8'h92, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 8'h44, 1'b1, 1'b1, 8'h93, 1'b1);
    #1;
    chk_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk_rdy("mid_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk_out("post_rst", 8'h44, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
